// File: rtl/pmc_host_loader_if.sv
// Host-side and PMC-side signal bundle for pmc_host_loader.
// master: the environment (command/word source and the PMC itself).
// slave:  the loader, which owns the PMC CPU bus pins and pin_START.
interface pmc_host_loader_if #(
    parameter int TMO_W = 16
);
    logic             cmd_load;
    logic [5:0]       load_addr;
    logic [6:0]       load_cnt;
    logic             word_valid;
    logic [35:0]      word_data;
    logic             word_ready;
    logic             cmd_run;
    logic [TMO_W-1:0] tmo_limit;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             pin_CS;
    logic             pin_NRD;
    logic             pin_BK;
    logic [12:0]      pin_AB;
    logic [7:0]       pin_DB;
    logic             pin_START;
    logic             pin_OUT0;

    modport master (
        output cmd_load, load_addr, load_cnt, word_valid, word_data,
               cmd_run, tmo_limit, pin_OUT0,
        input  word_ready, busy, done, timeout,
               pin_CS, pin_NRD, pin_BK, pin_AB, pin_DB, pin_START
    );

    modport slave (
        input  cmd_load, load_addr, load_cnt, word_valid, word_data,
               cmd_run, tmo_limit, pin_OUT0,
        output word_ready, busy, done, timeout,
               pin_CS, pin_NRD, pin_BK, pin_AB, pin_DB, pin_START
    );
endinterface

// File: rtl/pmc_host_loader.sv
// pmc_host_loader: loads the PMC 64x36 program RAM over its byte-wide CPU
// bus, writes the start PC, and runs the program until OUT0 goes low or the
// run timeout expires.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for cmd_load / cmd_run (load has priority)
// SETPC      | bus write AB=0x200, DB={1,0,load_addr}
// WAIT_WORD  | word_ready high, waiting for the next 36-bit program word
// BYTE0..4   | five bus writes AB=0x000 carrying the latched word, LSB first
// LDONE      | one-cycle done pulse closing a load
// RUN        | pin_START high; exits on synchronised OUT0 low or timeout
module pmc_host_loader #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int TMO_W      = 16
) (
    input  logic             clk,
    input  logic             pin_RST,
    pmc_host_loader_if.slave bus
);
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_SETPC     = 4'd1;
    localparam logic [3:0] ST_WAIT_WORD = 4'd2;
    localparam logic [3:0] ST_BYTE0     = 4'd3;
    localparam logic [3:0] ST_BYTE1     = 4'd4;
    localparam logic [3:0] ST_BYTE2     = 4'd5;
    localparam logic [3:0] ST_BYTE3     = 4'd6;
    localparam logic [3:0] ST_BYTE4     = 4'd7;
    localparam logic [3:0] ST_LDONE     = 4'd8;
    localparam logic [3:0] ST_RUN       = 4'd9;

    localparam logic [1:0] PH_SETUP  = 2'd0;
    localparam logic [1:0] PH_STROBE = 2'd1;
    localparam logic [1:0] PH_HOLD   = 2'd2;

    // Phase timers count down to zero; the loaded value is length-1.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

    // The PMC start synchroniser needs a few cycles before OUT0 reflects
    // the running program, so OUT0 is ignored for this many RUN cycles.
    localparam logic [2:0] IGN_LD = 3'd4;

    logic [3:0]       state;
    logic [1:0]       phase;
    logic [7:0]       ph_cnt;
    logic [6:0]       words_left;
    logic [27:0]      word_hi;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_lim;
    logic [2:0]       ign_cnt;
    logic             out0_s1;
    logic             out0_s2;
    logic             cs_q;
    logic [12:0]      ab_q;
    logic [7:0]       db_q;
    logic             start_q;
    logic             done_q;
    logic             tmo_q;
    logic [7:0]       next_byte;
    logic [6:0]       load_words;

    assign load_words     = (bus.load_cnt > 7'd64) ? 7'd64 : bus.load_cnt;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.word_ready = (state == ST_WAIT_WORD);
    assign bus.pin_CS     = cs_q;
    assign bus.pin_NRD    = 1'b1;
    assign bus.pin_BK     = 1'b0;
    assign bus.pin_AB     = ab_q;
    assign bus.pin_DB     = db_q;
    assign bus.pin_START  = start_q;
    assign bus.done       = done_q;
    assign bus.timeout    = tmo_q;

    // Byte to put on DB for the write that follows the current BYTEn state.
    always_comb begin
        next_byte = 8'h00;
        case (state)
            ST_BYTE0: next_byte = word_hi[7:0];
            ST_BYTE1: next_byte = word_hi[15:8];
            ST_BYTE2: next_byte = word_hi[23:16];
            ST_BYTE3: next_byte = {4'h0, word_hi[27:24]};
            default:  next_byte = 8'h00;
        endcase
    end

    // Two-flop synchroniser for the asynchronous PMC OUT0 flag (idle high).
    always_ff @(posedge clk or negedge pin_RST) begin
        if (!pin_RST) begin
            out0_s1 <= 1'b1;
            out0_s2 <= 1'b1;
        end else begin
            out0_s1 <= bus.pin_OUT0;
            out0_s2 <= out0_s1;
        end
    end

    // Main sequencer: command decode, bus write timing, run supervision.
    always_ff @(posedge clk or negedge pin_RST) begin
        if (!pin_RST) begin
            state      <= ST_IDLE;
            phase      <= PH_SETUP;
            ph_cnt     <= 8'd0;
            words_left <= 7'd0;
            word_hi    <= 28'd0;
            tmo_cnt    <= '0;
            tmo_lim    <= '0;
            ign_cnt    <= 3'd0;
            cs_q       <= 1'b1;
            ab_q       <= 13'h0000;
            db_q       <= 8'h00;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_load) begin
                        state      <= ST_SETPC;
                        words_left <= load_words;
                        ab_q       <= 13'h0200;
                        db_q       <= {2'b10, bus.load_addr};
                        phase      <= PH_SETUP;
                        ph_cnt     <= SETUP_LD;
                    end else if (bus.cmd_run) begin
                        state   <= ST_RUN;
                        start_q <= 1'b1;
                        tmo_cnt <= '0;
                        tmo_lim <= bus.tmo_limit;
                        ign_cnt <= IGN_LD;
                    end
                end

                ST_SETPC, ST_BYTE0, ST_BYTE1, ST_BYTE2, ST_BYTE3, ST_BYTE4: begin
                    case (phase)
                        PH_SETUP: begin
                            if (ph_cnt == 8'd0) begin
                                cs_q   <= 1'b0;
                                phase  <= PH_STROBE;
                                ph_cnt <= STROBE_LD;
                            end else begin
                                ph_cnt <= ph_cnt - 8'd1;
                            end
                        end
                        PH_STROBE: begin
                            if (ph_cnt == 8'd0) begin
                                cs_q   <= 1'b1;
                                phase  <= PH_HOLD;
                                ph_cnt <= HOLD_LD;
                            end else begin
                                ph_cnt <= ph_cnt - 8'd1;
                            end
                        end
                        PH_HOLD: begin
                            if (ph_cnt != 8'd0) begin
                                ph_cnt <= ph_cnt - 8'd1;
                            end else if (state == ST_SETPC) begin
                                if (words_left == 7'd0) begin
                                    state  <= ST_LDONE;
                                    done_q <= 1'b1;
                                end else begin
                                    state <= ST_WAIT_WORD;
                                end
                            end else if (state == ST_BYTE4) begin
                                words_left <= words_left - 7'd1;
                                if (words_left == 7'd1) begin
                                    state  <= ST_LDONE;
                                    done_q <= 1'b1;
                                end else begin
                                    state <= ST_WAIT_WORD;
                                end
                            end else begin
                                state  <= state + 4'd1;
                                ab_q   <= 13'h0000;
                                db_q   <= next_byte;
                                phase  <= PH_SETUP;
                                ph_cnt <= SETUP_LD;
                            end
                        end
                        default: begin
                            cs_q   <= 1'b1;
                            phase  <= PH_HOLD;
                            ph_cnt <= 8'd0;
                        end
                    endcase
                end

                ST_WAIT_WORD: begin
                    if (bus.word_valid) begin
                        word_hi <= bus.word_data[35:8];
                        state   <= ST_BYTE0;
                        ab_q    <= 13'h0000;
                        db_q    <= bus.word_data[7:0];
                        phase   <= PH_SETUP;
                        ph_cnt  <= SETUP_LD;
                    end
                end

                ST_LDONE: begin
                    state <= ST_IDLE;
                end

                ST_RUN: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (ign_cnt != 3'd0) begin
                        ign_cnt <= ign_cnt - 3'd1;
                    end
                    // Completion is checked first so it wins over a
                    // same-cycle timeout.
                    if (ign_cnt == 3'd0 && !out0_s2) begin
                        state   <= ST_IDLE;
                        start_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tmo_lim != '0 && tmo_cnt == tmo_lim - TMO_W'(1)) begin
                        state   <= ST_IDLE;
                        start_q <= 1'b0;
                        tmo_q   <= 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    cs_q    <= 1'b1;
                    start_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pmc_host_loader.sv
// Self-checking bench for pmc_host_loader: a schedule-based model of the
// expected bus writes, handshake and run outcome is compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_pmc_host_loader;
    localparam int SETUP  = 1;
    localparam int STROBE = 2;
    localparam int HOLD   = 1;
    localparam int TW     = 16;
    localparam int WLEN   = SETUP + STROBE + HOLD;

    logic clk = 1'b0;
    logic pin_RST = 1'b0;
    always #5 clk = ~clk;

    pmc_host_loader_if #(.TMO_W(TW)) bus ();

    pmc_host_loader #(
        .SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .HOLD_CYC(HOLD), .TMO_W(TW)
    ) dut (
        .clk(clk), .pin_RST(pin_RST), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (sample = one negedge) -------------
    int          cyc = 0;
    int          m_mode = 0;        // 0 idle, 1 load, 2 run
    logic [20:0] wq[$];             // pending writes {AB,DB}, front in flight
    int          wr_start = -1;
    int          pend_start = -1;
    int          words_left = 0;
    bit          want_word = 0;
    int          done_at = -1;
    int          tmo_at = -1;
    int          run_start = 0;
    int          run_lim = 0;
    logic [12:0] e_ab = 13'h0;
    logic [7:0]  e_db = 8'h0;
    bit          out0_h1 = 1, out0_h2 = 1;
    bit          prev_cs = 1;

    logic [20:0] wlog[$];
    int done_n = 0, tmo_n = 0, start_n = 0, rdy_n = 0, csl_n = 0;

    always @(negedge clk) begin : monitor
        int i;
        bit cs_e;
        logic [35:0] w;
        cyc++;
        if (!pin_RST) begin
            wq.delete();
            m_mode = 0; wr_start = -1; pend_start = -1; want_word = 0;
            words_left = 0; done_at = -1; tmo_at = -1;
            e_ab = 13'h0; e_db = 8'h0; prev_cs = 1;
            chk("rst_cs", bus.pin_CS, 1);
            chk("rst_busy", bus.busy, 0);
            chk("rst_start", bus.pin_START, 0);
            chk("rst_ab", bus.pin_AB, 0);
            chk("rst_db", bus.pin_DB, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_ready", bus.word_ready, 0);
        end else begin
            if (pend_start == cyc) begin
                wr_start = cyc; pend_start = -1;
                e_ab = wq[0][20:8]; e_db = wq[0][7:0];
            end else if (wr_start >= 0 && cyc == wr_start + WLEN) begin
                void'(wq.pop_front());
                if (wq.size() > 0) begin
                    wr_start = cyc;
                    e_ab = wq[0][20:8]; e_db = wq[0][7:0];
                end else begin
                    wr_start = -1;
                    if (words_left > 0) want_word = 1;
                    else done_at = cyc;
                end
            end
            cs_e = !(wr_start >= 0 && cyc >= wr_start + SETUP && cyc < wr_start + SETUP + STROBE);

            chk("cs", bus.pin_CS, cs_e);
            chk("ab", bus.pin_AB, e_ab);
            chk("db", bus.pin_DB, e_db);
            chk("busy", bus.busy, m_mode != 0);
            chk("word_ready", bus.word_ready, want_word);
            chk("done", bus.done, done_at == cyc);
            chk("timeout", bus.timeout, tmo_at == cyc);
            chk("start", bus.pin_START, m_mode == 2);
            chk("nrd", bus.pin_NRD, 1);
            chk("bk", bus.pin_BK, 0);

            if (prev_cs && !bus.pin_CS) wlog.push_back({bus.pin_AB, bus.pin_DB});
            prev_cs = bus.pin_CS;
            if (!bus.pin_CS) csl_n++;
            if (bus.done) done_n++;
            if (bus.timeout) tmo_n++;
            if (bus.pin_START) start_n++;
            if (bus.word_ready) rdy_n++;

            if (m_mode == 2) begin
                i = cyc - run_start;
                if (i >= 4 && !out0_h2) begin
                    m_mode = 0; done_at = cyc + 1;
                end else if (run_lim != 0 && i + 1 == run_lim) begin
                    m_mode = 0; tmo_at = cyc + 1;
                end
            end else if (m_mode == 1) begin
                if (want_word && bus.word_valid) begin
                    w = bus.word_data;
                    want_word = 0;
                    words_left--;
                    wq.push_back({13'h0, w[7:0]});
                    wq.push_back({13'h0, w[15:8]});
                    wq.push_back({13'h0, w[23:16]});
                    wq.push_back({13'h0, w[31:24]});
                    wq.push_back({13'h0, 4'h0, w[35:32]});
                    pend_start = cyc + 1;
                end
                if (done_at == cyc) m_mode = 0;
            end else begin
                if (bus.cmd_load) begin
                    m_mode = 1;
                    words_left = (bus.load_cnt > 7'd64) ? 64 : int'(bus.load_cnt);
                    wq.push_back({13'h200, 2'b10, bus.load_addr});
                    pend_start = cyc + 1;
                end else if (bus.cmd_run) begin
                    m_mode = 2;
                    run_start = cyc + 1;
                    run_lim = int'(bus.tmo_limit);
                end
            end
        end
        out0_h2 = out0_h1;
        out0_h1 = bus.pin_OUT0;
    end

    // ---------------- stimulus ---------------------------------------------
    logic [35:0] dir_words[$];
    int s_done, s_tmo, s_start, s_rdy, s_csl;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic snap();
        wlog.delete();
        s_done = done_n; s_tmo = tmo_n; s_start = start_n; s_rdy = rdy_n; s_csl = csl_n;
    endtask

    task automatic do_load(input logic [5:0] a, input logic [6:0] n, input bit dir,
                           input int gap, input bit also_run);
        int k = 0;
        int hold = 0;
        int budget = 0;
        bit acc;
        bus.load_addr = a;
        bus.load_cnt  = n;
        bus.cmd_load  = 1'b1;
        bus.cmd_run   = also_run;
        bus.tmo_limit = 16'd5;
        tick();
        bus.cmd_load = 1'b0;
        bus.cmd_run  = 1'b0;
        while (bus.busy && budget < 6000) begin
            if (dir) begin
                if (hold > 0) begin
                    bus.word_valid = 1'b0;
                    if (bus.word_ready) hold--;
                end else if (k < dir_words.size()) begin
                    bus.word_valid = 1'b1;
                    bus.word_data  = dir_words[k];
                end else begin
                    bus.word_valid = 1'b0;
                end
            end else begin
                bus.word_valid = ($urandom_range(3) != 0);
                bus.word_data  = {4'($urandom), 32'($urandom)};
            end
            acc = bus.word_valid && bus.word_ready;
            tick();
            budget++;
            if (dir && acc) begin
                k++;
                hold = gap;
            end
        end
        bus.word_valid = 1'b0;
        chk("load_finishes", bus.busy, 0);
        tick();
    endtask

    task automatic do_run(input int lim, input int fall_at);
        int i = 0;
        bus.tmo_limit = 16'(lim);
        bus.cmd_run = 1'b1;
        tick();
        bus.cmd_run = 1'b0;
        while (bus.busy && i < 3000) begin
            if (i == fall_at) bus.pin_OUT0 = 1'b0;
            tick();
            i++;
        end
        chk("run_finishes", bus.busy, 0);
        bus.pin_OUT0 = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        logic [20:0] t1_exp [6];
        int budget;
        int lim, fall;
        bus.cmd_load = 0; bus.load_addr = 0; bus.load_cnt = 0;
        bus.word_valid = 0; bus.word_data = 0; bus.cmd_run = 0;
        bus.tmo_limit = 0; bus.pin_OUT0 = 1;
        pin_RST = 1'b0;
        repeat (3) @(posedge clk);
        #2 pin_RST = 1'b1;
        repeat (2) tick();

        // single word load
        t1_exp = '{{13'h200, 8'h85}, {13'h0, 8'h78}, {13'h0, 8'h56},
                   {13'h0, 8'h34}, {13'h0, 8'h12}, {13'h0, 8'h0A}};
        dir_words = '{36'hA_1234_5678};
        snap();
        do_load(6'h05, 7'd1, 1, 0, 0);
        chk("t1_nwrites", wlog.size(), 6);
        for (int j = 0; j < 6 && j < wlog.size(); j++) chk("t1_write", wlog[j], t1_exp[j]);
        chk("t1_done", done_n - s_done, 1);
        chk("t1_cs_low", csl_n - s_csl, 12);

        // two words with a 10-cycle stall while word_ready is high
        dir_words = '{36'h3_CAFE_BABE, 36'hF_0011_2233};
        snap();
        do_load(6'h10, 7'd2, 1, 10, 0);
        chk("t2_nwrites", wlog.size(), 11);
        chk("t2_ready_cycles", rdy_n - s_rdy, 12);
        chk("t2_cs_low", csl_n - s_csl, 22);
        chk("t2_done", done_n - s_done, 1);

        // PC write only
        snap();
        do_load(6'h3F, 7'd0, 1, 0, 0);
        chk("t3_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) chk("t3_write", wlog[0], {13'h200, 8'hBF});
        chk("t3_ready", rdy_n - s_rdy, 0);
        chk("t3_done", done_n - s_done, 1);

        // run, OUT0 falls at run cycle 20
        snap();
        do_run(100, 20);
        chk("t4_start_cycles", start_n - s_start, 23);
        chk("t4_done", done_n - s_done, 1);
        chk("t4_timeout", tmo_n - s_tmo, 0);

        // run timeout
        snap();
        do_run(50, -1);
        chk("t5_start_cycles", start_n - s_start, 50);
        chk("t5_timeout", tmo_n - s_tmo, 1);
        chk("t5_done", done_n - s_done, 0);

        // completion and limit in the same cycle: done wins
        snap();
        do_run(30, 27);
        chk("t6_start_cycles", start_n - s_start, 30);
        chk("t6_done", done_n - s_done, 1);
        chk("t6_timeout", tmo_n - s_tmo, 0);

        // load and run requested together: load only
        dir_words = '{36'h5_5555_AAAA};
        snap();
        do_load(6'h01, 7'd1, 1, 0, 1);
        chk("t7_start", start_n - s_start, 0);
        chk("t7_nwrites", wlog.size(), 6);
        chk("t7_done", done_n - s_done, 1);

        // count above 64 is clamped
        snap();
        do_load(6'h00, 7'd70, 0, 0, 0);
        chk("t8_nwrites", wlog.size(), 1 + 64 * 5);

        // reset while CS is low during the BYTE2 write
        snap();
        bus.load_addr = 6'h2A; bus.load_cnt = 7'd3; bus.cmd_load = 1'b1;
        tick();
        bus.cmd_load = 1'b0;
        bus.word_valid = 1'b1; bus.word_data = 36'h9_8765_4321;
        budget = 0;
        while (!(wlog.size() >= 4 && bus.pin_CS == 1'b0) && budget < 200) begin
            tick();
            budget++;
        end
        chk("t9_reach_byte2_strobe", bus.pin_CS, 0);
        #1 pin_RST = 1'b0;
        #1;
        chk("t9_cs_async", bus.pin_CS, 1);
        chk("t9_busy_async", bus.busy, 0);
        bus.word_valid = 1'b0;
        tick(); tick();
        pin_RST = 1'b1;
        tick();
        chk("t9_busy_after", bus.busy, 0);
        chk("t9_cs_after", bus.pin_CS, 1);

        // randomized mix
        for (int r = 0; r < 16; r++) begin
            if ($urandom_range(1) == 1) begin
                do_load(6'($urandom), 7'($urandom_range(0, 9)), 0, 0, $urandom_range(3) == 0);
            end else begin
                lim = $urandom_range(0, 60);
                if (lim == 0) fall = $urandom_range(0, 40);
                else if ($urandom_range(1) == 1) fall = $urandom_range(0, lim + 5);
                else fall = -1;
                do_run(lim, fall);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
